alarm_ctrl_seq: RTL and testbench

- Parametrised sequential successor to the combinational light/door/ignition alarm.
- Raises a "lights left on" alarm only after the warning condition has held for a programmable delay.
- The alarm self-silences after a hold time and can be acknowledged by the driver.
- Supports N door sensors, records which doors were open at alarm time, and counts alarm events.
- Sits between the body-sensor inputs and the buzzer driver.

---
 rtl/alarm_pkg.sv | 24 ++
 rtl/alarm_dncnt.sv | 39 +++
 rtl/alarm_ctrl_seq.sv | 138 +++++++++++++
 tb/tb_alarm_ctrl_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the sequential lights-left-on alarm: state encoding
// and compile-time sizing helpers.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2,
    ST_MUTE  = 2'd3
  } state_e;

  // Bits needed to hold the values 0..v-1 (at least 1 bit).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_dncnt.sv
// Loadable down counter with a zero flag. Load has priority over decrement;
// decrementing at zero is never requested by the controller.
module alarm_dncnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load, decrement or hold.
  always_comb begin
    // NOTE: assigning a default first means every path writes cnt_d, so no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_ctrl_seq.sv
// Lights-left-on alarm controller: arms after the warning condition has held
// for DELAY_CYCLES, sounds for up to HOLD_CYCLES, can be acknowledged, latches
// the open doors at alarm time and counts alarm events (saturating).
module alarm_ctrl_seq
  import alarm_pkg::*;
#(
  parameter int N_DOORS      = 4,
  parameter int DELAY_CYCLES = 8,
  parameter int HOLD_CYCLES  = 16,
  parameter int EVT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sLuz,
  input  logic [N_DOORS-1:0] sPrta,
  input  logic               sIgn,
  input  logic               sAck,
  output logic               sAlarm,
  output logic [1:0]         sState,
  output logic [N_DOORS-1:0] sDoorLatch,
  output logic [EVT_W-1:0]   sEvtCnt
);

  localparam int CW = clog2(max_int(DELAY_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CW-1:0] DELAY_LD = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

  state_e             state_q;
  logic               alarm_q;
  logic [N_DOORS-1:0] door_latch_q;
  logic [EVT_W-1:0]   evt_cnt_q;
  logic [EVT_W-1:0]   evt_cnt_d;

  logic               cond;
  logic               cnt_load;
  logic [CW-1:0]      cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CW-1:0]      cnt_val;

  assign cond = sLuz & ~sIgn & (|sPrta);

  // Saturating increment of the event counter.
  assign evt_cnt_d = (evt_cnt_q == '1) ? evt_cnt_q : evt_cnt_q + EVT_W'(1);

  // Counter control: load the delay on arming, the hold time on firing,
  // otherwise count down while PEND or an unacknowledged ALARM persists.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = DELAY_LD;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cond) cnt_load = 1'b1;
      end
      ST_PEND: begin
        if (cond) begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (cond && !sAck && !cnt_zero) cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  alarm_dncnt #(
    .CW(CW)
  ) u_dncnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Main FSM with registered buzzer, door snapshot and event count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alarm_q      <= 1'b0;
      door_latch_q <= '0;
      evt_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cond) state_q <= ST_PEND;
        end
        ST_PEND: begin
          if (!cond) begin
            state_q      <= ST_IDLE;
            door_latch_q <= '0;
          end else if (cnt_zero) begin
            state_q      <= ST_ALARM;
            alarm_q      <= 1'b1;
            door_latch_q <= sPrta;
            evt_cnt_q    <= evt_cnt_d;
          end
        end
        ST_ALARM: begin
          // Losing the condition outranks acknowledge and auto-mute.
          if (!cond) begin
            state_q      <= ST_IDLE;
            alarm_q      <= 1'b0;
            door_latch_q <= '0;
          end else if (sAck || cnt_zero) begin
            state_q <= ST_MUTE;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          if (!cond) begin
            state_q      <= ST_IDLE;
            door_latch_q <= '0;
          end
        end
      endcase
    end
  end

  assign sAlarm     = alarm_q;
  assign sState     = state_q;
  assign sDoorLatch = door_latch_q;
  assign sEvtCnt    = evt_cnt_q;

  // The raw count value is only consumed through its zero flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_alarm_ctrl_seq.sv
// Self-checking bench for alarm_ctrl_seq. The reference model tracks how many
// consecutive edges the warning condition has held and whether the driver
// acknowledged; every output is derived from those two facts.
module tb_alarm_ctrl_seq;

  localparam int N = 4;
  localparam int D = 8;
  localparam int H = 16;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sLuz;
  logic [N-1:0] sPrta;
  logic         sIgn;
  logic         sAck;
  logic         sAlarm;
  logic [1:0]   sState;
  logic [N-1:0] sDoorLatch;
  logic [E-1:0] sEvtCnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int           run_len;
  bit           acked;
  logic [N-1:0] m_latch;
  int           m_evt;

  always #5 clk = ~clk;

  alarm_ctrl_seq #(
    .N_DOORS(N), .DELAY_CYCLES(D), .HOLD_CYCLES(H), .EVT_W(E)
  ) dut (
    .clk(clk), .reset(reset), .sLuz(sLuz), .sPrta(sPrta), .sIgn(sIgn),
    .sAck(sAck), .sAlarm(sAlarm), .sState(sState),
    .sDoorLatch(sDoorLatch), .sEvtCnt(sEvtCnt)
  );

  function automatic logic [1:0] m_state();
    if (run_len == 0)                 return 2'd0;
    if (run_len <= D)                 return 2'd1;
    if (run_len <= D + H && !acked)   return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [14:0] m_vec();
    logic [1:0] s;
    s = m_state();
    return {(s == 2'd2), s, m_latch, E'(m_evt)};
  endfunction

  task automatic model_reset();
    run_len = 0; acked = 0; m_latch = '0; m_evt = 0;
  endtask

  // Advance the model on the current inputs, then clock the DUT.
  task automatic step();
    bit cond;
    cond = sLuz && !sIgn && (sPrta != '0);
    if (!cond) begin
      run_len = 0; acked = 0; m_latch = '0;
    end else begin
      if (m_state() == 2'd2 && sAck) acked = 1;
      if (run_len <= D + H) run_len++;
      if (run_len == D + 1) begin
        m_latch = sPrta;
        if (m_evt < (1 << E) - 1) m_evt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic luz, input logic [N-1:0] prta,
                       input logic ign, input logic ack);
    sLuz = luz; sPrta = prta; sIgn = ign; sAck = ack;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== 15'd0) begin
      $display("FAIL reset_state got=%h exp=%h", {sAlarm, sState, sDoorLatch, sEvtCnt}, 15'd0);
      n_err++;
    end
    n_vec++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    drive(1, 4'b0010, 0, 0);
    for (int i = 1; i <= D + H + 3; i++) begin
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
        $display("FAIL basic[%0d] got=%h exp=%h", i, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
      if (i == D && sAlarm !== 1'b0) begin
        $display("FAIL basic_early got=%b exp=0", sAlarm); n_err++;
      end
      if (i == D + 1 && sAlarm !== 1'b1) begin
        $display("FAIL basic_fire got=%b exp=1", sAlarm); n_err++;
      end
      if (i == D + H + 1 && {sAlarm, sState, sDoorLatch, sEvtCnt} !== {1'b0, 2'd3, 4'b0010, 8'd1}) begin
        $display("FAIL basic_mute got=%h exp=%h", {sAlarm, sState, sDoorLatch, sEvtCnt},
                 {1'b0, 2'd3, 4'b0010, 8'd1});
        n_err++;
      end
      if (i == D || i == D + 1 || i == D + H + 1) n_vec++;
    end
    drive(0, 4'b0010, 0, 0);
    step();
  endtask

  task automatic test_restart();
    drive(1, 4'b0100, 0, 0);
    repeat (5) step();
    sPrta = '0;
    step();
    sPrta = 4'b0100;
    for (int i = 1; i <= D + 2; i++) begin
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
        $display("FAIL restart[%0d] got=%h exp=%h", i, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
    end
    drive(0, '0, 0, 0);
    step();
  endtask

  task automatic test_ack();
    drive(1, 4'b1001, 0, 0);
    repeat (D + 3) step();
    sAck = 1'b1;
    step();
    sAck = 1'b0;
    if (sState !== 2'd3 || sAlarm !== 1'b0) begin
      $display("FAIL ack_mute got=%0d/%b exp=3/0", sState, sAlarm); n_err++;
    end
    n_vec++;
    for (int i = 0; i < 50; i++) begin
      sAck = (i % 7 == 3);
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
        $display("FAIL ack_hold[%0d] got=%h exp=%h", i, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
    end
    drive(0, 4'b1001, 0, 0);
    step();
    if (sState !== 2'd0 || sDoorLatch !== 4'b0000) begin
      $display("FAIL ack_clear got=%0d/%b exp=0/0000", sState, sDoorLatch); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_ign_ack();
    drive(1, 4'b0001, 0, 0);
    repeat (D + 4) step();
    sIgn = 1'b1; sAck = 1'b1;
    step();
    if ({sAlarm, sState} !== 3'b000 || {sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
      $display("FAIL ign_ack got=%h exp=%h", {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
      n_err++;
    end
    n_vec++;
    drive(0, '0, 0, 0);
    step();
  endtask

  task automatic test_door_change();
    drive(1, 4'b0110, 0, 0);
    repeat (D + 2) step();
    for (int i = 0; i < 6; i++) begin
      sPrta = (i % 2 == 0) ? 4'b1000 : 4'b0011;
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec() || sDoorLatch !== 4'b0110) begin
        $display("FAIL door_change[%0d] got=%h exp=%h", i, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
    end
    drive(0, '0, 0, 0);
    step();
  endtask

  task automatic test_async_reset();
    drive(1, 4'b0010, 0, 0);
    repeat (D + 3) step();
    if (sAlarm !== 1'b1) begin
      $display("FAIL areset_pre got=%b exp=1", sAlarm); n_err++;
    end
    n_vec++;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    if ({sAlarm, sState, sEvtCnt} !== 11'd0 || sDoorLatch !== 4'b0000) begin
      $display("FAIL areset got=%h exp=%h", {sAlarm, sState, sDoorLatch, sEvtCnt}, 15'd0);
      n_err++;
    end
    n_vec++;
    #2;
    reset = 1'b0;
    drive(0, '0, 0, 0);
    step();
  endtask

  task automatic test_random();
    drive(1, 4'b0101, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) sLuz  = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) sIgn  = ($urandom_range(4) == 0);
      if ($urandom_range(5) == 0) sPrta = N'($urandom);
      sAck = ($urandom_range(15) == 0);
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
        $display("FAIL random[%0d] got=%h exp=%h", i, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
    end
    drive(0, '0, 0, 0);
    step();
  endtask

  task automatic test_saturation();
    for (int ev = 0; ev < 300; ev++) begin
      drive(1, N'(ev % 15 + 1), 0, 0);
      repeat (D + 1) step();
      drive(0, '0, 0, 0);
      step();
      if ({sAlarm, sState, sDoorLatch, sEvtCnt} !== m_vec()) begin
        $display("FAIL sat[%0d] got=%h exp=%h", ev, {sAlarm, sState, sDoorLatch, sEvtCnt}, m_vec());
        n_err++;
      end
      n_vec++;
    end
    if (sEvtCnt !== 8'hFF) begin
      $display("FAIL sat_final got=%h exp=ff", sEvtCnt); n_err++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_ack();
    test_ign_ack();
    test_door_change();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
